iob_eth_buf_rd: RTL

Frame-buffer reader for the Ethernet core. It drains one frame from the simple-dual-port frame memory by driving that memory's read port, which has a 2-cycle read latency. It delivers the words as a valid/ready stream with a last marker to the transmit path. Backpressure on the stream is absorbed by a small credit-controlled FIFO, so no word read from memory is ever lost.

---
 rtl/iob_eth_buf_rd_pkg.sv | 14 +
 rtl/iob_eth_buf_rd_fifo.sv | 51 +++++
 rtl/iob_eth_buf_rd.sv | 133 +++++++++++++
 3 files changed

// File: rtl/iob_eth_buf_rd_pkg.sv
// Shared encodings and sizing for the Ethernet frame-buffer reader.
package iob_eth_buf_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/iob_eth_buf_rd_fifo.sv
// Small synchronous FIFO of {last, data}; head is visible combinationally (zero-latency read).
// No internal overflow guard: the writer limits pushes through credits, and pops are valid-gated by the user.
module iob_eth_buf_rd_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count == '0);

endmodule

// File: rtl/iob_eth_buf_rd.sv
// Drains one frame from the 2-cycle-latency frame memory into a valid/ready stream; first beat 4 cycles after start.
// Reads are issued only while in-flight + queued words fit the FIFO, so backpressure never drops data. IOB_ETH_BUF_RD_BASE_EN adds base_addr.
module iob_eth_buf_rd #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
`ifdef IOB_ETH_BUF_RD_BASE_EN
  input  logic [ADDR_W-1:0] base_addr,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  import iob_eth_buf_rd_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ISS_ONE = (ADDR_W + 1)'(1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   issue_cnt_q;
  logic [RD_LAT-1:0] vld_sr_q;
  logic [RD_LAT-1:0] last_sr_q;
  logic [ADDR_W-1:0] start_addr;

  logic              issue;
  logic              last_issue;
  logic [CNT_W:0]    occupancy;
  logic              pop;
  logic              drain_done;
  logic [DATA_W:0]   fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;

`ifdef IOB_ETH_BUF_RD_BASE_EN
  assign start_addr = base_addr;
`else
  assign start_addr = '0;
`endif

  // Credit: every word already requested or queued holds a FIFO slot.
  always_comb begin
    occupancy = {1'b0, fifo_count};
    for (int i = 0; i < RD_LAT; i++) begin
      occupancy = occupancy + {{CNT_W{1'b0}}, vld_sr_q[i]};
    end
  end

  assign issue      = (state_q == ST_READ) && (occupancy < DEPTH_C);
  assign last_issue = issue && (issue_cnt_q == ISS_ONE);
  assign pop        = out_valid && out_ready;
  assign drain_done = (vld_sr_q == '0) && pop && fifo_head[DATA_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        addr_q      <= start_addr;
        issue_cnt_q <= len;
      end else if (issue) begin
        addr_q      <= addr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q - 1'b1;
      end
      // Tag pipeline mirrors the memory read latency so push lines up with mem_rdata.
      vld_sr_q  <= {vld_sr_q[RD_LAT-2:0], issue};
      last_sr_q <= {last_sr_q[RD_LAT-2:0], last_issue};
    end
  end

  iob_eth_buf_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_sr_q[RD_LAT-1]),
    .push_data ({last_sr_q[RD_LAT-1], mem_rdata}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_addr  = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_last  = out_valid && fifo_head[DATA_W];

endmodule
